// File: rtl/bs_gnrtr_n_rbtr.sv
// Bus generator and arbiter: per-bus round-robin grant over device transmit FIFOs,
// then a unicast or broadcast push of the popped packet to the receive ports.
module bs_gnrtr_n_rbtr #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]              pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] PUSH = 2'd2;

  // Device 0 gets first priority out of reset.
  localparam logic [7:0] LAST_INIT = 8'(drvrs - 1);

  for (genvar b = 0; b < bits; b++) begin : g_bus
    logic [1:0]         state_r;
    logic [7:0]         last_r;
    logic [7:0]         src_r;
    logic [pckg_sz-1:0] pkt_r;
    logic [drvrs-1:0]   pop_r;
    logic [drvrs-1:0]   push_r;
    logic [pckg_sz-1:0] dpush_r;

    logic [drvrs-1:0]   hi_req_s;
    logic [drvrs-1:0]   req_s;
    logic [drvrs-1:0]   gnt_oh_s;
    logic [drvrs-1:0]   push_dec_s;
    logic [7:0]         gnt_s;
    logic [7:0]         id_s;
    logic               any_s;
    logic [pckg_sz-1:0] gnt_pkt_s;

    // Round-robin grant: lowest pending index above last wins, else lowest pending overall.
    always_comb begin
      hi_req_s  = {drvrs{1'b0}};
      gnt_oh_s  = {drvrs{1'b0}};
      gnt_s     = 8'd0;
      gnt_pkt_s = {pckg_sz{1'b0}};
      any_s     = |pndng[b];
      for (int d = 0; d < drvrs; d++) begin
        hi_req_s[d] = pndng[b][d] & (8'(d) > last_r);
      end
      req_s = (|hi_req_s) ? hi_req_s : pndng[b];
      for (int d = drvrs - 1; d >= 0; d--) begin
        gnt_s = req_s[d] ? 8'(d) : gnt_s;
      end
      for (int d = 0; d < drvrs; d++) begin
        gnt_oh_s[d] = (8'(d) == gnt_s);
        gnt_pkt_s   = gnt_oh_s[d] ? D_pop[b][d] : gnt_pkt_s;
      end
    end

    // Destination decode; an ID that is neither broadcast nor a real device matches no bit.
    always_comb begin
      id_s       = pkt_r[pckg_sz-1 -: 8];
      push_dec_s = {drvrs{1'b0}};
      for (int d = 0; d < drvrs; d++) begin
        push_dec_s[d] = (id_s == broadcast) ? (8'(d) != src_r) : (8'(d) == id_s);
      end
    end

    // Per-bus IDLE -> POP -> PUSH sequencer with registered strobes and data.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r <= IDLE;
        last_r  <= LAST_INIT;
        src_r   <= 8'd0;
        pkt_r   <= {pckg_sz{1'b0}};
        pop_r   <= {drvrs{1'b0}};
        push_r  <= {drvrs{1'b0}};
        dpush_r <= {pckg_sz{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            push_r <= {drvrs{1'b0}};
            if (any_s) begin
              pop_r   <= gnt_oh_s;
              pkt_r   <= gnt_pkt_s;
              src_r   <= gnt_s;
              last_r  <= gnt_s;
              state_r <= POP;
            end else begin
              pop_r   <= {drvrs{1'b0}};
              state_r <= IDLE;
            end
          end
          POP: begin
            pop_r   <= {drvrs{1'b0}};
            push_r  <= push_dec_s;
            dpush_r <= pkt_r;
            state_r <= PUSH;
          end
          PUSH: begin
            pop_r   <= {drvrs{1'b0}};
            push_r  <= {drvrs{1'b0}};
            state_r <= IDLE;
          end
          default: begin
            pop_r   <= {drvrs{1'b0}};
            push_r  <= {drvrs{1'b0}};
            state_r <= IDLE;
          end
        endcase
      end
    end

    assign pop[b]  = pop_r;
    assign push[b] = push_r;
    for (genvar d = 0; d < drvrs; d++) begin : g_dev
      assign D_push[b][d] = dpush_r;
    end
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Directed bench for bs_gnrtr_n_rbtr: 1 bus, 4 devices, 16-bit packets,
// with a small FWFT FIFO model per device and a negedge event monitor.
module tb_bs_gnrtr_n_rbtr;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [0:0][3:0]        pndng = '0;
  logic [0:0][3:0][15:0]  D_pop = '0;
  logic [0:0][3:0]        pop;
  logic [0:0][3:0]        push;
  logic [0:0][3:0][15:0]  D_push;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inv_err = 0;
  logic [3:0] prev_pop = 4'b0000;
  logic [3:0] prev_push = 4'b0000;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] q3[$];

  int          pop_cyc_q[$];
  logic [3:0]  pop_vec_q[$];
  int          push_cyc_q[$];
  logic [3:0]  push_vec_q[$];
  logic [15:0] push_dat_q[$];

  bs_gnrtr_n_rbtr #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Device FIFO model plus event log and strobe-shape monitor.
  always @(negedge clk) begin
    if (pop[0] != 4'b0000) begin
      pop_cyc_q.push_back(cyc);
      pop_vec_q.push_back(pop[0]);
      if (pop[0][0] && q0.size() > 0) void'(q0.pop_front());
      if (pop[0][1] && q1.size() > 0) void'(q1.pop_front());
      if (pop[0][2] && q2.size() > 0) void'(q2.pop_front());
      if (pop[0][3] && q3.size() > 0) void'(q3.pop_front());
    end
    if (push[0] != 4'b0000) begin
      push_cyc_q.push_back(cyc);
      push_vec_q.push_back(push[0]);
      push_dat_q.push_back(D_push[0][0]);
    end
    if (((pop[0] != 4'b0000) && (push[0] != 4'b0000)) || ($countones(pop[0]) > 1) ||
        ((pop[0] != 4'b0000) && (prev_pop != 4'b0000)) ||
        ((push[0] != 4'b0000) && (prev_push != 4'b0000)))
      inv_err <= inv_err + 1;
    prev_pop  <= pop[0];
    prev_push <= push[0];
    pndng[0][0] <= (q0.size() != 0);
    pndng[0][1] <= (q1.size() != 0);
    pndng[0][2] <= (q2.size() != 0);
    pndng[0][3] <= (q3.size() != 0);
    D_pop[0][0] <= (q0.size() != 0) ? q0[0] : 16'h0000;
    D_pop[0][1] <= (q1.size() != 0) ? q1[0] : 16'h0000;
    D_pop[0][2] <= (q2.size() != 0) ? q2[0] : 16'h0000;
    D_pop[0][3] <= (q3.size() != 0) ? q3[0] : 16'h0000;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_cyc_q.delete();
    pop_vec_q.delete();
    push_cyc_q.delete();
    push_vec_q.delete();
    push_dat_q.delete();
  endtask

  task automatic load(input int d, input logic [15:0] v);
    case (d)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++;
    if (pop[0] !== 4'b0000) begin errors++; $display("FAIL reset_pop: got %b want 0000", pop[0]); end
    checks++;
    if (push[0] !== 4'b0000) begin errors++; $display("FAIL reset_push: got %b want 0000", push[0]); end
    checks++;
    if (D_push[0] !== 64'h0) begin errors++; $display("FAIL reset_dpush: got %h want 0", D_push[0]); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_unicast();
    int c;
    clear_logs();
    c = cyc;
    load(0, 16'h0255);
    tick(8);
    checks++;
    if (pop_vec_q.size() !== 1) begin errors++; $display("FAIL uni_pop_count: got %0d want 1", pop_vec_q.size()); end
    checks++;
    if (pop_vec_q[0] !== 4'b0001) begin errors++; $display("FAIL uni_pop_vec: got %b want 0001", pop_vec_q[0]); end
    checks++;
    if (pop_cyc_q[0] !== c + 1) begin errors++; $display("FAIL uni_pop_cycle: got %0d want %0d", pop_cyc_q[0], c + 1); end
    checks++;
    if (push_vec_q.size() !== 1) begin errors++; $display("FAIL uni_push_count: got %0d want 1", push_vec_q.size()); end
    checks++;
    if (push_vec_q[0] !== 4'b0100) begin errors++; $display("FAIL uni_push_vec: got %b want 0100", push_vec_q[0]); end
    checks++;
    if (push_cyc_q[0] !== c + 2) begin errors++; $display("FAIL uni_push_cycle: got %0d want %0d", push_cyc_q[0], c + 2); end
    checks++;
    if (push_dat_q[0] !== 16'h0255) begin errors++; $display("FAIL uni_data: got %h want 0255", push_dat_q[0]); end
    checks++;
    if (D_push[0][2] !== 16'h0255) begin errors++; $display("FAIL uni_hold: got %h want 0255", D_push[0][2]); end
  endtask

  task automatic test_broadcast();
    clear_logs();
    load(1, 16'hFF12);
    tick(8);
    checks++;
    if (pop_vec_q[0] !== 4'b0010) begin errors++; $display("FAIL bc_pop_vec: got %b want 0010", pop_vec_q[0]); end
    checks++;
    if (push_vec_q[0] !== 4'b1101) begin errors++; $display("FAIL bc_push_vec: got %b want 1101", push_vec_q[0]); end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (D_push[0][d] !== 16'hFF12) begin errors++; $display("FAIL bc_data[%0d]: got %h want FF12", d, D_push[0][d]); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_pop  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0]  exp_push [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [15:0] exp_dat  [4] = '{16'h01A0, 16'h02A1, 16'h03A2, 16'h00A3};
    int c;
    do_reset();
    clear_logs();
    c = cyc;
    for (int d = 0; d < 4; d++) load(d, exp_dat[d]);
    tick(20);
    checks++;
    if (pop_vec_q.size() !== 4) begin errors++; $display("FAIL rr_pop_count: got %0d want 4", pop_vec_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pop_vec_q[i] !== exp_pop[i]) begin errors++; $display("FAIL rr_pop[%0d]: got %b want %b", i, pop_vec_q[i], exp_pop[i]); end
      checks++;
      if (pop_cyc_q[i] !== c + 1 + 3 * i) begin errors++; $display("FAIL rr_cycle[%0d]: got %0d want %0d", i, pop_cyc_q[i], c + 1 + 3 * i); end
      checks++;
      if (push_vec_q[i] !== exp_push[i]) begin errors++; $display("FAIL rr_push[%0d]: got %b want %b", i, push_vec_q[i], exp_push[i]); end
      checks++;
      if (push_dat_q[i] !== exp_dat[i]) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, push_dat_q[i], exp_dat[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_pop [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    logic [15:0] exp_dat [5] = '{16'h01B0, 16'h02B1, 16'h03B2, 16'h00B5, 16'h01B4};
    do_reset();
    clear_logs();
    load(0, 16'h01B0);
    load(1, 16'h02B1);
    load(2, 16'h03B2);
    load(2, 16'h01B4);
    load(3, 16'h00B5);
    tick(25);
    checks++;
    if (pop_vec_q.size() !== 5) begin errors++; $display("FAIL b2b_pop_count: got %0d want 5", pop_vec_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pop_vec_q[i] !== exp_pop[i]) begin errors++; $display("FAIL b2b_pop[%0d]: got %b want %b", i, pop_vec_q[i], exp_pop[i]); end
      checks++;
      if (push_dat_q[i] !== exp_dat[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, push_dat_q[i], exp_dat[i]); end
    end
  endtask

  task automatic test_invalid_id();
    clear_logs();
    load(3, 16'h07AA);
    tick(8);
    checks++;
    if (pop_vec_q.size() !== 1) begin errors++; $display("FAIL inv_pop_count: got %0d want 1", pop_vec_q.size()); end
    checks++;
    if (pop_vec_q[0] !== 4'b1000) begin errors++; $display("FAIL inv_pop_vec: got %b want 1000", pop_vec_q[0]); end
    checks++;
    if (push_vec_q.size() !== 0) begin errors++; $display("FAIL inv_push_count: got %0d want 0", push_vec_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    load(0, 16'h0255);
    n = 0;
    @(negedge clk);
    while (pop[0] == 4'b0000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pop[0] !== 4'b0001) begin errors++; $display("FAIL mid_pop_seen: got %b want 0001 (timeout %0d)", pop[0], n); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pop[0] !== 4'b0000) begin errors++; $display("FAIL mid_pop: got %b want 0000", pop[0]); end
    checks++;
    if (push[0] !== 4'b0000) begin errors++; $display("FAIL mid_push: got %b want 0000", push[0]); end
    checks++;
    if (D_push[0] !== 64'h0) begin errors++; $display("FAIL mid_dpush: got %h want 0", D_push[0]); end
    reset = 1'b0;
    tick(6);
    checks++;
    if (push_vec_q.size() !== 0) begin errors++; $display("FAIL mid_lost: got %0d pushes want 0", push_vec_q.size()); end
    clear_logs();
    load(3, 16'h0022);
    load(0, 16'h0311);
    tick(10);
    checks++;
    if (pop_vec_q[0] !== 4'b0001) begin errors++; $display("FAIL mid_prio_first: got %b want 0001", pop_vec_q[0]); end
    checks++;
    if (pop_vec_q[1] !== 4'b1000) begin errors++; $display("FAIL mid_prio_second: got %b want 1000", pop_vec_q[1]); end
  endtask

  task automatic test_self_address();
    clear_logs();
    load(1, 16'h0133);
    tick(8);
    checks++;
    if (push_vec_q[0] !== 4'b0010) begin errors++; $display("FAIL self_push_vec: got %b want 0010", push_vec_q[0]); end
    checks++;
    if (push_dat_q[0] !== 16'h0133) begin errors++; $display("FAIL self_data: got %h want 0133", push_dat_q[0]); end
  endtask

  task automatic test_strobe_shape();
    checks++;
    if (inv_err !== 0) begin errors++; $display("FAIL strobe_shape: got %0d violations want 0", inv_err); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_round_robin();
    test_back_to_back();
    test_invalid_id();
    test_reset_mid();
    test_self_address();
    test_strobe_shape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
